// File: rtl/vote_pkg.sv
// Shared types, mode encodings and helpers for the vote tally engine.
package vote_pkg;

  localparam int unsigned ONEHOT_MAX_W = 32;

  typedef enum logic [1:0] {
    VOTE   = 2'd0,
    SCAN   = 2'd1,
    RESULT = 2'd2
  } state_t;

  localparam logic MODE_VOTE   = 1'b0;
  localparam logic MODE_RESULT = 1'b1;

  // True when exactly one bit of vec is set.
  function automatic logic onehot_ok(input logic [ONEHOT_MAX_W-1:0] vec);
    return (vec != '0) && ((vec & (vec - ONEHOT_MAX_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/vote_tally_engine_if.sv
// Vote input / tally output bundle between the front end and the tally engine.
interface vote_tally_engine_if #(
  parameter int unsigned NUM_CAND = 4,
  parameter int unsigned CNT_W    = 8
);
  localparam int unsigned IDX_W = $clog2(NUM_CAND);

  logic                      mode;
  logic [NUM_CAND-1:0]       vote_valid;
  logic [NUM_CAND*CNT_W-1:0] vote_count;
  logic [CNT_W+IDX_W-1:0]    total_votes;
  logic [NUM_CAND-1:0]       cand_sat;
  logic                      vote_reject;
  logic [IDX_W-1:0]          winner_idx;
  logic                      winner_valid;
  logic                      tie;

  modport master (
    output mode, vote_valid,
    input  vote_count, total_votes, cand_sat, vote_reject, winner_idx, winner_valid, tie
  );

  modport slave (
    input  mode, vote_valid,
    output vote_count, total_votes, cand_sat, vote_reject, winner_idx, winner_valid, tie
  );
endinterface

// File: rtl/vote_cand_counter.sv
// Saturating per-candidate vote counter; sat flags the all-ones count.
module vote_cand_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_en,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  assign sat = (count == {CNT_W{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc_en && !sat) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/vote_tally_engine.sv
// Vote tally engine: one-hot vote counting in VOTE mode, sequential winner scan in result mode.
module vote_tally_engine
  import vote_pkg::*;
#(
  parameter int unsigned NUM_CAND = 4,
  parameter int unsigned CNT_W    = 8
) (
  input logic                 clk,
  input logic                 rst,
  vote_tally_engine_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(NUM_CAND);
  localparam int unsigned TOT_W = CNT_W + IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CAND - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt [NUM_CAND];
  logic [NUM_CAND-1:0] sat;
  logic [NUM_CAND-1:0] inc_en;
  logic [IDX_W-1:0]    scan_idx;
  logic [CNT_W-1:0]    best;
  logic [TOT_W-1:0]    total;
  logic [IDX_W-1:0]    winner_idx;
  logic                winner_valid;
  logic                tie;
  logic                vote_reject;
  logic                any_vote;
  logic                counting;
  logic                accept;

  // A vote counts only when idle-voting, single-hot and not hitting a saturated candidate.
  assign any_vote = |bus.vote_valid;
  assign counting = (state_q == VOTE) && (bus.mode == MODE_VOTE);
  assign accept   = counting && onehot_ok(ONEHOT_MAX_W'(bus.vote_valid))
                    && ((bus.vote_valid & sat) == '0);
  assign inc_en   = accept ? bus.vote_valid : '0;

  for (genvar i = 0; i < NUM_CAND; i++) begin : g_cand
    vote_cand_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .inc_en (inc_en[i]),
      .count  (cnt[i]),
      .sat    (sat[i])
    );
    assign bus.vote_count[i*CNT_W +: CNT_W] = cnt[i];
  end

  assign bus.cand_sat     = sat;
  assign bus.total_votes  = total;
  assign bus.vote_reject  = vote_reject;
  assign bus.winner_idx   = winner_idx;
  assign bus.winner_valid = winner_valid;
  assign bus.tie          = tie;

  always_ff @(posedge clk) begin
    if (rst) state_q <= VOTE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      VOTE:    if (bus.mode == MODE_RESULT) state_d = SCAN;
      SCAN: begin
        if (bus.mode == MODE_VOTE)   state_d = VOTE;
        else if (scan_idx == LAST_IDX) state_d = RESULT;
      end
      RESULT:  if (bus.mode == MODE_VOTE) state_d = VOTE;
      default: state_d = VOTE;
    endcase
  end

  // Total, reject pulse and the scan comparator; an aborted scan never publishes.
  always_ff @(posedge clk) begin
    if (rst) begin
      total        <= '0;
      vote_reject  <= 1'b0;
      scan_idx     <= '0;
      best         <= '0;
      winner_idx   <= '0;
      winner_valid <= 1'b0;
      tie          <= 1'b0;
    end else begin
      vote_reject <= any_vote && !accept;
      if (accept) total <= total + TOT_W'(1);

      case (state_q)
        VOTE: begin
          if (state_d == SCAN) begin
            scan_idx   <= '0;
            best       <= '0;
            winner_idx <= '0;
            tie        <= 1'b0;
          end
        end
        SCAN: begin
          if (state_d == VOTE) begin
            tie <= 1'b0;
          end else begin
            if (cnt[scan_idx] > best) begin
              best       <= cnt[scan_idx];
              winner_idx <= scan_idx;
              tie        <= 1'b0;
            end else if ((cnt[scan_idx] == best) && (scan_idx != '0)) begin
              tie <= 1'b1;
            end
            if (state_d == RESULT) winner_valid <= 1'b1;
            else                   scan_idx     <= scan_idx + IDX_W'(1);
          end
        end
        RESULT: begin
          if (state_d == VOTE) begin
            winner_valid <= 1'b0;
            tie          <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
